pbuff_vga_scanout: RTL

PBUFF_VGA_SCANOUT -- requirements
Module: pbuff_vga_scanout

---
 rtl/pbuff_vga_scanout.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/pbuff_vga_scanout.sv
// Pixel-buffer VGA scan-out: a 160x120 4-bit framebuffer written from a
// processor PIO strobe and replicated 4x per axis onto 640x480@60 timing.
module pbuff_vga_scanout #(
    parameter int FB_W  = 160,
    parameter int FB_H  = 120,
    parameter int SCALE = 4
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic [14:0] pb_adr_export,
    input  logic [3:0]  pb_data_export,
    input  logic        pbuff_wren_export,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        pbuff_err
);

    localparam int          PIX_N   = FB_W * FB_H;
    localparam logic [14:0] PIX_LIM = 15'(PIX_N);

    localparam logic [9:0] H_LAST   = 10'd799;
    localparam logic [9:0] H_VIS    = 10'd640;
    localparam logic [9:0] HS_FIRST = 10'd656;
    localparam logic [9:0] HS_LAST  = 10'd751;
    localparam logic [9:0] V_LAST   = 10'd524;
    localparam logic [9:0] V_VIS    = 10'd480;
    localparam logic [9:0] VS_FIRST = 10'd490;
    localparam logic [9:0] VS_LAST  = 10'd491;

    // ------------------------------------------------------------------
    // Write side
    // ------------------------------------------------------------------
    logic wren_q;
    logic err_q;
    logic wr_fire;
    logic wr_in_range;

    // A write is the single cycle where the level strobe has just risen.
    assign wr_fire     = pbuff_wren_export & ~wren_q;
    assign wr_in_range = (pb_adr_export < PIX_LIM);

    // Strobe history (reset high so a strobe held through reset is ignored)
    // and the sticky out-of-range flag.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            wren_q <= 1'b1;
            err_q  <= 1'b0;
        end else begin
            wren_q <= pbuff_wren_export;
            if (wr_fire && !wr_in_range) begin
                err_q <= 1'b1;
            end
        end
    end

    // Framebuffer storage; contents survive reset.
    logic [3:0] fb_mem [PIX_N];

    // Write port: one RAM write per strobe edge, in-range addresses only.
    always_ff @(posedge clk_clk) begin
        if (wr_fire && wr_in_range) begin
            fb_mem[pb_adr_export] <= pb_data_export;
        end
    end

    // ------------------------------------------------------------------
    // Timing generator
    // ------------------------------------------------------------------
    logic       pix_en_q;
    logic [9:0] h_cnt_q, h_cnt_d;
    logic [9:0] v_cnt_q, v_cnt_d;

    // Next counter values: advance one pixel per pix_en, wrap at line/frame end.
    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (pix_en_q) begin
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = 10'd0;
                v_cnt_d = (v_cnt_q == V_LAST) ? 10'd0 : v_cnt_q + 10'd1;
            end else begin
                h_cnt_d = h_cnt_q + 10'd1;
            end
        end
    end

    // Pixel-rate enable and raster counters.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            pix_en_q <= 1'b0;
            h_cnt_q  <= 10'd0;
            v_cnt_q  <= 10'd0;
        end else begin
            pix_en_q <= ~pix_en_q;
            h_cnt_q  <= h_cnt_d;
            v_cnt_q  <= v_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Scan-out pipeline: address -> RAM read -> palette
    // ------------------------------------------------------------------
    logic        act_d, hsy_d, vsy_d;
    logic [14:0] rd_adr_d;

    // Stage-1 inputs decoded from the current raster position; the address
    // is forced to zero while blanked so the RAM is never indexed past its end.
    always_comb begin
        act_d    = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
        hsy_d    = (h_cnt_q >= HS_FIRST) && (h_cnt_q <= HS_LAST);
        vsy_d    = (v_cnt_q >= VS_FIRST) && (v_cnt_q <= VS_LAST);
        rd_adr_d = 15'd0;
        if (act_d) begin
            rd_adr_d = 15'((int'(v_cnt_q) / SCALE) * FB_W + int'(h_cnt_q) / SCALE);
        end
    end

    logic [14:0] adr1_q;
    logic        act1_q, hsy1_q, vsy1_q;
    logic [3:0]  rd_data_q;
    logic        act2_q, hsy2_q, vsy2_q;
    logic        vga_hs_q, vga_vs_q;
    logic [3:0]  vga_r_q, vga_g_q, vga_b_q;

    // Palette: each of R/G/B is a 2-level intensity selected together with I.
    logic [3:0] pal_col [3];
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_pal
            assign pal_col[gi] = rd_data_q[gi] ? (rd_data_q[3] ? 4'hF : 4'hA)
                                               : (rd_data_q[3] ? 4'h5 : 4'h0);
        end
    endgenerate

    // Three pipeline stages; syncs and the active flag travel alongside the
    // pixel so colour and sync for a raster position leave together.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            adr1_q    <= 15'd0;
            act1_q    <= 1'b0;
            hsy1_q    <= 1'b0;
            vsy1_q    <= 1'b0;
            rd_data_q <= 4'd0;
            act2_q    <= 1'b0;
            hsy2_q    <= 1'b0;
            vsy2_q    <= 1'b0;
            vga_hs_q  <= 1'b1;
            vga_vs_q  <= 1'b1;
            vga_r_q   <= 4'd0;
            vga_g_q   <= 4'd0;
            vga_b_q   <= 4'd0;
        end else if (pix_en_q) begin
            adr1_q    <= rd_adr_d;
            act1_q    <= act_d;
            hsy1_q    <= hsy_d;
            vsy1_q    <= vsy_d;
            rd_data_q <= fb_mem[adr1_q];
            act2_q    <= act1_q;
            hsy2_q    <= hsy1_q;
            vsy2_q    <= vsy1_q;
            vga_hs_q  <= ~hsy2_q;
            vga_vs_q  <= ~vsy2_q;
            vga_r_q   <= act2_q ? pal_col[2] : 4'h0;
            vga_g_q   <= act2_q ? pal_col[1] : 4'h0;
            vga_b_q   <= act2_q ? pal_col[0] : 4'h0;
        end
    end

    assign vga_hs    = vga_hs_q;
    assign vga_vs    = vga_vs_q;
    assign vga_r     = vga_r_q;
    assign vga_g     = vga_g_q;
    assign vga_b     = vga_b_q;
    assign pbuff_err = err_q;

endmodule
